// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte, steps start/data/parity/stop,
// and drives the TX line mux select plus its serial-data and parity inputs.
module uart_tx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  SER_DATA,
   output logic                  PAR_BIT,
   output logic [1:0]            MUX_SEL,
   output logic                  BUSY
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   localparam logic [1:0] SEL_START  = 2'b00;
   localparam logic [1:0] SEL_IDLE   = 2'b01;
   localparam logic [1:0] SEL_DATA   = 2'b10;
   localparam logic [1:0] SEL_PARITY = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_par_en;
   logic                  r_par_bit;
   logic [1:0]            r_mux_sel;
   logic                  r_busy;
   logic [1:0]            w_mux_sel;
   logic                  w_busy;
   logic                  w_accept;

   // A new frame may only start from idle or in the stop bit of the previous one.
   assign w_accept = DATA_VALID && ((r_state == S_IDLE) || (r_state == S_STOP));

   always_comb begin
      w_next_state = r_state;
      w_mux_sel    = SEL_IDLE;
      w_busy       = 1'b1;

      case (r_state)
         S_IDLE:   if (w_accept) w_next_state = S_START;
         S_START:  w_next_state = S_DATA;
         S_DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_next_state = r_par_en ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: w_next_state = S_STOP;
         S_STOP:   w_next_state = w_accept ? S_START : S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase

      // Select and busy are registered off the next state so outputs come straight from flops.
      case (w_next_state)
         S_IDLE: begin
            w_mux_sel = SEL_IDLE;
            w_busy    = 1'b0;
         end
         S_START:  w_mux_sel = SEL_START;
         S_DATA:   w_mux_sel = SEL_DATA;
         S_PARITY: w_mux_sel = SEL_PARITY;
         S_STOP:   w_mux_sel = SEL_IDLE;
         default: begin
            w_mux_sel = SEL_IDLE;
            w_busy    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_mux_sel <= SEL_IDLE;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_mux_sel <= w_mux_sel;
         r_busy    <= w_busy;
      end
   end

   // Payload shifter, bit counter and per-frame parity settings.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_shift   <= '0;
         r_cnt     <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
      end else if (w_accept) begin
         r_shift   <= P_DATA;
         r_cnt     <= '0;
         r_par_en  <= PAR_EN;
         r_par_bit <= (^P_DATA) ^ PAR_TYP;
      end else begin
         case (r_state)
            S_START: r_cnt <= '0;
            S_DATA: begin
               r_shift <= r_shift >> 1;
               if (r_cnt != CNT_LAST) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_shift <= r_shift;
               r_cnt   <= r_cnt;
            end
         endcase
      end
   end

   assign SER_DATA = r_shift[0];
   assign PAR_BIT  = r_par_bit;
   assign MUX_SEL  = r_mux_sel;
   assign BUSY     = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a per-bit-period frame model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_tx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] P_DATA = 8'h00;
   logic       DATA_VALID = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       SER_DATA;
   logic       PAR_BIT;
   logic [1:0] MUX_SEL;
   logic       BUSY;

   int checks = 0;
   int failures = 0;

   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .SER_DATA(SER_DATA),
      .PAR_BIT(PAR_BIT), .MUX_SEL(MUX_SEL), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One entry per bit period on the line.
   typedef struct {
      logic [1:0] mux;
      logic       ser;
      logic       chk_ser;
      logic       busy;
      logic       is_stop;
   } rec_t;

   rec_t q[$];
   rec_t cur;
   logic m_par = 1'b0;

   function automatic rec_t mk(input logic [1:0] mux, input logic ser, input logic cs,
                               input logic busy, input logic st);
      rec_t r;
      r.mux = mux; r.ser = ser; r.chk_ser = cs; r.busy = busy; r.is_stop = st;
      return r;
   endfunction

   // Reference model: on acceptance, lay out the whole frame as a list of bit periods.
   always @(posedge CLK) begin
      if (RST) begin
         q.delete();
         cur   = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
         m_par = 1'b0;
      end else begin
         if (DATA_VALID && (!cur.busy || cur.is_stop)) begin
            q.delete();
            m_par = (^P_DATA) ^ PAR_TYP;
            q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
            for (int i = 0; i < 8; i++) q.push_back(mk(2'b10, P_DATA[i], 1'b1, 1'b1, 1'b0));
            if (PAR_EN) q.push_back(mk(2'b11, 1'b0, 1'b0, 1'b1, 1'b0));
            q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b1));
         end
         if (q.size() > 0) cur = q.pop_front();
         else              cur = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      #1;
      chk("mux_sel", 32'(MUX_SEL), 32'(cur.mux));
      chk("busy", 32'(BUSY), 32'(cur.busy));
      chk("par_bit", 32'(PAR_BIT), 32'(m_par));
      if (cur.chk_ser) chk("ser_data", 32'(SER_DATA), 32'(cur.ser));
   end

   // Present one frame request and record the line for nsamp bit periods starting at START.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input int nsamp, output logic [23:0] mtr,
                             output logic [7:0] sb, output int bc);
      @(negedge CLK);
      P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; DATA_VALID = 1'b1;
      mtr = '0; sb = '0; bc = 0;
      for (int i = 0; i < nsamp; i++) begin
         @(posedge CLK); #2;
         mtr = {mtr[21:0], MUX_SEL};
         if (MUX_SEL == 2'b10) sb = {SER_DATA, sb[7:1]};
         bc += int'(BUSY);
         if (i == 0) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
         end
      end
   endtask

   logic [23:0] mtr;
   logic [7:0]  sb, sb2;
   int          bc;

   initial begin
      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_mux", 32'(MUX_SEL), 32'h1);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_ser", 32'(SER_DATA), 32'h0);
      chk("rst_par", 32'(PAR_BIT), 32'h0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // 0xA5 even parity: 11-cycle frame then idle
      send_frame(8'hA5, 1'b1, 1'b0, 12, mtr, sb, bc);
      chk("a5_even_mux_seq", 32'(mtr), 32'({2'b00, {8{2'b10}}, 2'b11, 2'b01, 2'b01}));
      chk("a5_even_ser", 32'(sb), 32'hA5);
      chk("a5_even_par", 32'(PAR_BIT), 32'h0);
      chk("a5_even_busy_len", 32'(bc), 32'd11);
      chk("model_par_a5_even", 32'(m_par), 32'h0);

      send_frame(8'hA5, 1'b1, 1'b1, 12, mtr, sb, bc);
      chk("a5_odd_par", 32'(PAR_BIT), 32'h1);

      send_frame(8'h01, 1'b1, 1'b1, 12, mtr, sb, bc);
      chk("01_odd_par", 32'(PAR_BIT), 32'h0);
      chk("model_par_01_odd", 32'(m_par), 32'h0);

      // No parity: 10-cycle frame, select never 11
      send_frame(8'h3C, 1'b0, 1'b0, 11, mtr, sb, bc);
      chk("3c_mux_seq", 32'(mtr), 32'({2'b00, {8{2'b10}}, 2'b01, 2'b01}));
      chk("3c_ser", 32'(sb), 32'h3C);
      chk("3c_busy_len", 32'(bc), 32'd10);

      // Back-to-back: valid held, 0xAA presented during STOP of the 0x55 frame
      @(negedge CLK);
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      sb = '0; sb2 = '0; bc = 0;
      for (int i = 0; i < 21; i++) begin
         @(posedge CLK); #2;
         bc += int'(BUSY);
         if (MUX_SEL == 2'b10) begin
            if (i < 10) sb = {SER_DATA, sb[7:1]};
            else        sb2 = {SER_DATA, sb2[7:1]};
         end
         if (i == 10) chk("b2b_start_after_stop", 32'(MUX_SEL), 32'h0);
         if (i == 9 || i == 10) begin
            @(negedge CLK);
            if (i == 9) P_DATA = 8'hAA;
            else        DATA_VALID = 1'b0;
         end
      end
      chk("b2b_first", 32'(sb), 32'h55);
      chk("b2b_second", 32'(sb2), 32'hAA);
      chk("b2b_busy_len", 32'(bc), 32'd20);

      // Requests during DATA and PARITY are ignored
      @(negedge CLK);
      P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      sb = '0; mtr = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK); #2;
         mtr = {mtr[21:0], MUX_SEL};
         if (MUX_SEL == 2'b10) sb = {SER_DATA, sb[7:1]};
         if (i == 0 || i == 3 || i == 4 || i == 9 || i == 10) begin
            @(negedge CLK);
            DATA_VALID = (i == 3 || i == 9);
            if (i == 3 || i == 9) begin
               P_DATA = 8'hFF; PAR_TYP = 1'b1;
            end
         end
      end
      chk("ign_mux_seq", 32'(mtr), 32'({2'b00, {8{2'b10}}, 2'b11, 2'b01, 2'b01}));
      chk("ign_ser", 32'(sb), 32'h5A);
      chk("ign_par", 32'(PAR_BIT), 32'h0);
      chk("ign_idle_busy", 32'(BUSY), 32'h0);

      // Async reset during DATA bit 3
      @(negedge CLK);
      P_DATA = 8'hC3; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #2;
         if (i == 0) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
         end
      end
      chk("pre_rst_data", 32'(MUX_SEL), 32'h2);
      #1 RST = 1'b1;
      #1;
      chk("mid_rst_mux", 32'(MUX_SEL), 32'h1);
      chk("mid_rst_busy", 32'(BUSY), 32'h0);
      chk("mid_rst_par", 32'(PAR_BIT), 32'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      chk("post_rst_idle_mux", 32'(MUX_SEL), 32'h1);
      chk("post_rst_idle_busy", 32'(BUSY), 32'h0);

      // Randomized traffic, including held requests and occasional resets
      for (int c = 0; c < 2000; c++) begin
         @(negedge CLK);
         RST        = ($urandom_range(0, 199) == 0);
         DATA_VALID = ($urandom_range(0, 3) == 0);
         P_DATA     = 8'($urandom);
         PAR_EN     = 1'($urandom);
         PAR_TYP    = 1'($urandom);
      end
      @(negedge CLK);
      RST = 1'b0; DATA_VALID = 1'b0;
      repeat (15) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencing controller for the UART transmitter output path. It accepts a parallel byte, then generates the 2-bit output-select code for the TX line mux (start / idle-stop / serial data / parity). It also supplies the mux's serial-data and parity inputs from an internal shift register and parity generator. It sits between the register-file/FIFO side of UART_TX and the TX output mux, clocked by the TX baud clock: one CLK cycle is one bit period.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the parallel payload.

Ports:
- CLK  input  1  TX baud clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel payload, sampled only on frame acceptance.
- DATA_VALID  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = append parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
- SER_DATA  output  1  current payload bit (to mux data input).
- PAR_BIT  output  1  computed parity of the accepted frame (to mux parity input).
- MUX_SEL  output  2  mux select: 00 start (0), 01 idle/stop (1), 10 SER_DATA, 11 PAR_BIT.
- BUSY  output  1  high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- MUX_SEL is decoded from the registered state:
  - IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
  - 2'b11 is never produced while PAR_EN was 0 at acceptance.
- BUSY = 0 in IDLE, 1 in all other states.
- Acceptance:
  - Occurs when DATA_VALID=1 at a rising edge with state IDLE or STOP.
  - Loads P_DATA into the shift register and latches PAR_EN/PAR_TYP.
  - Computes PAR_BIT = ^P_DATA XOR PAR_TYP.
  - Sets next state to START.
- DATA_VALID in START, DATA or PARITY is ignored. There is no queuing; the requester must hold or re-assert.
- IDLE: no acceptance → stay in IDLE.
- START → DATA after 1 cycle; the bit counter is cleared.
- DATA:
  - SER_DATA = shift-register bit 0, so the payload goes out LSB first.
  - Shift right each cycle; counter increments.
  - After DATA_WIDTH cycles (counter = DATA_WIDTH-1): go to PARITY if the latched PAR_EN = 1, else STOP.
- PARITY → STOP after 1 cycle.
- STOP:
  - Acceptance → START. This gives back-to-back frames with no idle gap, and BUSY stays 1.
  - Otherwise → IDLE.
- PAR_BIT holds its value until the next acceptance. P_DATA, PAR_EN and PAR_TYP changes mid-frame have no effect.
- Counter width is clog2(DATA_WIDTH). The counter never wraps past DATA_WIDTH-1.

## Timing
- Reset (async, immediate, in any state including mid-frame):
  - Outputs: state IDLE, MUX_SEL=01, BUSY=0, SER_DATA=0, PAR_BIT=0.
  - Internals: shift register 0, counter 0, latched PAR_EN=0, PAR_TYP=0.
  - A frame in progress is aborted. The line returns to idle-high in the same cycle.
- Acceptance at edge n:
  - Cycle n+1: START (MUX_SEL=00, BUSY=1).
  - Cycles n+2 .. n+1+DATA_WIDTH: DATA, bits 0..DATA_WIDTH-1.
  - Then PARITY for 1 cycle, if enabled.
  - Then STOP for 1 cycle.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity (10 / 11 at default).
- BUSY rises in the cycle after acceptance. It falls in the cycle after STOP unless a back-to-back acceptance occurred.
- All outputs are glitch-free functions of registers only. There is no combinational path from any input to any output.

## Test plan
- Reset mid-frame: assert RST during DATA bit 3 → same cycle MUX_SEL=01, BUSY=0. After release, line stays idle until DATA_VALID.
- 0xA5, PAR_EN=1, PAR_TYP=0:
  - MUX_SEL sequence is 00, 10×8, 11, 01.
  - SER_DATA during DATA = 1,0,1,0,0,1,0,1.
  - PAR_BIT=0; BUSY high for 11 cycles.
- 0xA5, PAR_EN=1, PAR_TYP=1 → PAR_BIT=1.
- 0x01, PAR_EN=1, PAR_TYP=1 → PAR_BIT=0.
- 0x3C, PAR_EN=0 → 10-cycle frame; MUX_SEL never 11; SER_DATA = 0,0,1,1,1,1,0,0.
- Back-to-back: DATA_VALID held high with 0x55 then 0xAA presented at the STOP cycle → START immediately follows STOP, BUSY never drops, second payload is 0xAA.
- DATA_VALID pulsed during DATA and PARITY, with P_DATA changed to 0xFF → ignored; current frame bits unchanged; controller returns to IDLE after STOP.
